// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with occupancy count, threshold flags, sticky
// overflow/underflow errors and selectable standard or first-word-fall-through reads.
module fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_MARGIN  = 2,
  parameter int AE_MARGIN  = 2,
  parameter int FWFT       = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    read,
  input  logic                    write,
  input  logic                    clear_err,
  input  logic [DATA_WIDTH-1:0]   inputBus,
  output logic [DATA_WIDTH-1:0]   outputBus,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty,
  output logic                    full,
  output logic                    almost_empty,
  output logic                    almost_full,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LEVEL   = CW'(DEPTH - AF_MARGIN);
  localparam logic [CW-1:0] AE_LEVEL   = CW'(AE_MARGIN);
  localparam logic          AF_RESET   = (AF_LEVEL == '0);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic                  ae_q, ae_d;
  logic                  af_q, af_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  wr_ok, rd_ok;

  always_comb begin
    rd_ok    = read & ~empty_q;
    wr_ok    = write & (~full_q | read);

    wr_ptr_d = wr_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;

    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    empty_d = (count_d == '0);
    full_d  = (count_d == FULL_LEVEL);
    ae_d    = (count_d <= AE_LEVEL);
    af_d    = (count_d >= AF_LEVEL);

    // A new error in the same cycle as clear_err keeps the flag set.
    ovf_d = (ovf_q & ~clear_err) | (write & full_q & ~read);
    unf_d = (unf_q & ~clear_err) | (read & empty_q);

    if (FWFT != 0) begin
      // Register the post-edge head word; forward inputBus when it lands
      // in the slot that becomes the head (write into an empty FIFO).
      if (wr_ok && (wr_ptr_q == rd_ptr_d)) dout_d = inputBus;
      else                                 dout_d = mem_q[rd_ptr_d];
    end else begin
      dout_d = rd_ok ? mem_q[rd_ptr_q] : dout_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ae_q     <= 1'b1;
      af_q     <= AF_RESET;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ae_q     <= ae_d;
      af_q     <= af_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= inputBus;
  end

  assign outputBus    = dout_q;
  assign count        = count_q;
  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_empty = ae_q;
  assign almost_full  = af_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param: a standard-read instance and an FWFT instance,
// both DEPTH=4, checked against hand-computed expected values.
module tb_fifo_param;

  logic clk;
  logic rst;

  logic       s_rd, s_wr, s_clr;
  logic [7:0] s_din, s_dout;
  logic [2:0] s_cnt;
  logic       s_empty, s_full, s_ae, s_af, s_ovf, s_unf;

  logic       f_rd, f_wr, f_clr;
  logic [7:0] f_din, f_dout;
  logic [2:0] f_cnt;
  logic       f_empty, f_full, f_ae, f_af, f_ovf, f_unf;

  int total = 0;
  int bad   = 0;

  fifo_param #(.DATA_WIDTH(8), .DEPTH(4), .AF_MARGIN(1), .AE_MARGIN(1), .FWFT(0)) u_std (
    .clk(clk), .reset(rst), .read(s_rd), .write(s_wr), .clear_err(s_clr),
    .inputBus(s_din), .outputBus(s_dout), .count(s_cnt), .empty(s_empty),
    .full(s_full), .almost_empty(s_ae), .almost_full(s_af),
    .overflow(s_ovf), .underflow(s_unf)
  );

  fifo_param #(.DATA_WIDTH(8), .DEPTH(4), .AF_MARGIN(1), .AE_MARGIN(1), .FWFT(1)) u_fwft (
    .clk(clk), .reset(rst), .read(f_rd), .write(f_wr), .clear_err(f_clr),
    .inputBus(f_din), .outputBus(f_dout), .count(f_cnt), .empty(f_empty),
    .full(f_full), .almost_empty(f_ae), .almost_full(f_af),
    .overflow(f_ovf), .underflow(f_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic s_step(input logic rd, input logic wr, input logic clr, input logic [7:0] d);
    s_rd = rd; s_wr = wr; s_clr = clr; s_din = d;
    @(posedge clk); #1;
    s_rd = 1'b0; s_wr = 1'b0; s_clr = 1'b0;
  endtask

  task automatic f_step(input logic rd, input logic wr, input logic [7:0] d);
    f_rd = rd; f_wr = wr; f_din = d;
    @(posedge clk); #1;
    f_rd = 1'b0; f_wr = 1'b0;
  endtask

  task automatic s_status(input string tag, input int cnt, input logic emp, input logic ful);
    check_eq({tag, ".count"}, 32'(s_cnt), 32'(cnt));
    check_eq({tag, ".empty"}, 32'(s_empty), 32'(emp));
    check_eq({tag, ".full"},  32'(s_full),  32'(ful));
  endtask

  logic [7:0] exp_dout;
  int         exp_cnt;

  initial begin
    rst = 1'b0;
    s_rd = 0; s_wr = 0; s_clr = 0; s_din = '0;
    f_rd = 0; f_wr = 0; f_clr = 0; f_din = '0;
    #1 rst = 1'b1;
    #2;
    s_status("rst", 0, 1'b1, 1'b0);
    check_eq("rst.ae",   32'(s_ae),   32'd1);
    check_eq("rst.af",   32'(s_af),   32'd0);
    check_eq("rst.dout", 32'(s_dout), 32'h00);
    check_eq("rst.ovf",  32'(s_ovf),  32'd0);
    check_eq("rst.unf",  32'(s_unf),  32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Basic order and latency
    s_step(0, 1, 0, 8'h11); s_status("b.w1", 1, 1'b0, 1'b0);
    s_step(0, 1, 0, 8'h22); s_status("b.w2", 2, 1'b0, 1'b0);
    s_step(0, 1, 0, 8'h33); s_status("b.w3", 3, 1'b0, 1'b0);
    s_step(1, 0, 0, 8'h00); check_eq("b.r1", 32'(s_dout), 32'h11); s_status("b.r1", 2, 1'b0, 1'b0);
    s_step(1, 0, 0, 8'h00); check_eq("b.r2", 32'(s_dout), 32'h22); s_status("b.r2", 1, 1'b0, 1'b0);
    s_step(1, 0, 0, 8'h00); check_eq("b.r3", 32'(s_dout), 32'h33); s_status("b.r3", 0, 1'b1, 1'b0);

    // Full and overflow
    for (int i = 0; i < 4; i++) s_step(0, 1, 0, 8'hA0 + 8'(i));
    s_status("f.fill", 4, 1'b0, 1'b1);
    check_eq("f.ovf0", 32'(s_ovf), 32'd0);
    s_step(0, 1, 0, 8'hA4);
    s_status("f.w5", 4, 1'b0, 1'b1);
    check_eq("f.ovf1", 32'(s_ovf), 32'd1);
    for (int i = 0; i < 4; i++) begin
      s_step(1, 0, 0, 8'h00);
      check_eq("f.drain", 32'(s_dout), 32'hA0 + 32'(i));
    end
    s_status("f.drained", 0, 1'b1, 1'b0);
    check_eq("f.ovf_sticky", 32'(s_ovf), 32'd1);
    s_step(0, 0, 1, 8'h00);
    check_eq("f.ovf_clr", 32'(s_ovf), 32'd0);

    // Empty and underflow
    s_step(1, 0, 0, 8'h00);
    check_eq("u.unf", 32'(s_unf), 32'd1);
    check_eq("u.dout_hold", 32'(s_dout), 32'hA3);
    s_status("u.rd_empty", 0, 1'b1, 1'b0);
    s_step(1, 1, 0, 8'h5A);
    s_status("u.rw_empty", 1, 1'b0, 1'b0);
    check_eq("u.unf_stay", 32'(s_unf), 32'd1);
    check_eq("u.dout_rw", 32'(s_dout), 32'hA3);
    s_step(1, 0, 0, 8'h00);
    check_eq("u.r5a", 32'(s_dout), 32'h5A);
    // clear_err coinciding with a fresh underflow keeps the flag set
    s_step(1, 0, 1, 8'h00);
    check_eq("u.clr_vs_new", 32'(s_unf), 32'd1);
    s_step(0, 0, 1, 8'h00);
    check_eq("u.unf_clr", 32'(s_unf), 32'd0);

    // Full with simultaneous read and write
    for (int i = 0; i < 4; i++) s_step(0, 1, 0, 8'hB0 + 8'(i));
    s_step(1, 1, 0, 8'hB4);
    s_status("rw.full", 4, 1'b0, 1'b1);
    check_eq("rw.ovf", 32'(s_ovf), 32'd0);
    check_eq("rw.dout", 32'(s_dout), 32'hB0);
    for (int i = 1; i < 5; i++) begin
      s_step(1, 0, 0, 8'h00);
      check_eq("rw.drain", 32'(s_dout), 32'hB0 + 32'(i));
    end
    s_status("rw.drained", 0, 1'b1, 1'b0);

    // Thresholds and pointer wrap: 10 words, occupancy 1..3
    exp_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 3) begin
        s_step(0, 1, 0, 8'h40 + 8'(i));
        exp_cnt++;
      end else begin
        s_step(1, 1, 0, 8'h40 + 8'(i));
        exp_dout = 8'h40 + 8'(i - 3);
        check_eq("t.rw_data", 32'(s_dout), 32'(exp_dout));
      end
      check_eq("t.cnt", 32'(s_cnt), 32'(exp_cnt));
      check_eq("t.ae",  32'(s_ae),  (exp_cnt <= 1) ? 32'd1 : 32'd0);
      check_eq("t.af",  32'(s_af),  (exp_cnt >= 3) ? 32'd1 : 32'd0);
    end
    for (int i = 7; i < 10; i++) begin
      s_step(1, 0, 0, 8'h00);
      exp_cnt--;
      check_eq("t.drain", 32'(s_dout), 32'h40 + 32'(i));
      check_eq("t.cnt_d", 32'(s_cnt), 32'(exp_cnt));
      check_eq("t.ae_d",  32'(s_ae),  (exp_cnt <= 1) ? 32'd1 : 32'd0);
      check_eq("t.af_d",  32'(s_af),  (exp_cnt >= 3) ? 32'd1 : 32'd0);
    end

    // FWFT instance and asynchronous reset mid-stream
    check_eq("fw.rst_empty", 32'(f_empty), 32'd1);
    f_step(0, 1, 8'hC1);
    check_eq("fw.c1_dout",  32'(f_dout),  32'hC1);
    check_eq("fw.c1_empty", 32'(f_empty), 32'd0);
    check_eq("fw.c1_cnt",   32'(f_cnt),   32'd1);
    f_step(0, 1, 8'hC2);
    check_eq("fw.c2_dout", 32'(f_dout), 32'hC1);
    check_eq("fw.c2_cnt",  32'(f_cnt),  32'd2);
    f_step(1, 0, 8'h00);
    check_eq("fw.pop_dout", 32'(f_dout), 32'hC2);
    check_eq("fw.pop_cnt",  32'(f_cnt),  32'd1);
    rst = 1'b1;
    #2;
    check_eq("fw.ar_cnt",   32'(f_cnt),   32'd0);
    check_eq("fw.ar_empty", 32'(f_empty), 32'd1);
    check_eq("fw.ar_full",  32'(f_full),  32'd0);
    check_eq("fw.ar_ae",    32'(f_ae),    32'd1);
    check_eq("fw.ar_af",    32'(f_af),    32'd0);
    check_eq("fw.ar_ovf",   32'(f_ovf),   32'd0);
    check_eq("fw.ar_unf",   32'(f_unf),   32'd0);
    check_eq("fw.ar_scnt",  32'(s_cnt),   32'd0);
    @(posedge clk); #1 rst = 1'b0;
    f_step(0, 1, 8'hD0);
    check_eq("fw.d0_dout",  32'(f_dout),  32'hD0);
    check_eq("fw.d0_empty", 32'(f_empty), 32'd0);
    f_step(0, 1, 8'hD1);
    check_eq("fw.d1_head", 32'(f_dout), 32'hD0);
    f_step(1, 0, 8'h00);
    check_eq("fw.d1_pop", 32'(f_dout), 32'hD1);
    f_step(1, 0, 8'h00);
    check_eq("fw.final_empty", 32'(f_empty), 32'd1);
    check_eq("fw.final_cnt",   32'(f_cnt),   32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
